decode_ctrl_stage: RTL and testbench
====================================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered RV32I/RV64I decode stage: combinational opcode decode plus an elastic ID/EX output
//  buffer with valid/ready handshake, flush, immediate generation and illegal-opcode detection.
//  Sits between the fetch/IF-ID register and the execute stage.
//  Supersedes the combinational controller: adds pipelining, back-pressure, LUI/AUIPC writeback
//  and a decoded-instruction counter.
// PARAMETERS
//  XLEN   32  datapath width (32 or 64); sets pc_i/pc_o/imm_o width and sign-extension target
//  SKID   1   1: two-entry skid buffer, in_ready_o is a flop output; 0: single register
//  CNT_W  16  width of dec_cnt_o
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush_i    in   1     discard all buffered entries and the current input
//  in_valid_i in   1     instr_i/pc_i valid
//  in_ready_o out  1     stage can accept
//  instr_i    in   32    instruction word
//  pc_i       in   XLEN  instruction PC
//  out_valid_o out 1     decoded entry valid
//  out_ready_i in  1     execute stage accepts
//  pc_o       out  XLEN  PC of head entry
//  imm_o      out  XLEN  sign-extended immediate (I/S/B/U/J by opcode; 0 for OP/illegal)
//  rd_o,rs1_o,rs2_o out 5 each   instr[11:7], [19:15], [24:20]
//  funct3_o   out  3     instr[14:12]
//  funct7_o   out  7     instr[31:25]
//  ctrl_o     out  14    {illegal,lui,auipc,jal,jalr,op_imm,alu_op[1:0],branch,mem_write,mem_read,reg_write,mem_to_reg,alu_src}
//  dec_cnt_o  out  CNT_W count of entries transferred (out_valid_o&&out_ready_i), saturating
// BEHAVIOUR
//  Decode, per opcode instr[6:0]:
//   LOAD 0000011: alu_src,mem_to_reg,mem_read,reg_write; imm I
//   STORE 0100011: alu_src,mem_write; imm S
//   OP 0110011: reg_write, alu_op=10; imm 0
//   OP-IMM 0010011: alu_src,reg_write,op_imm, alu_op=10; imm I
//   BRANCH 1100011: branch, alu_op=01; imm B
//   JAL 1101111: jal,reg_write; imm J.  JALR 1100111: jalr,reg_write,alu_src; imm I
//   LUI 0110111: lui,reg_write; imm U.  AUIPC 0010111: auipc,reg_write; imm U
//   other opcode, or instr[1:0]!=2'b11: illegal=1, all other ctrl bits 0, imm 0
//   mem_write is asserted only for STORE; every ctrl bit not listed for an opcode is 0
//   U-imm = {instr[31:12],12'b0}, sign-extended to XLEN
//  Handshake:
//   - input accepted when in_valid_i && in_ready_o && !flush_i
//   - output transfer when out_valid_o && out_ready_i
//   - payload is held stable while out_valid_o && !out_ready_i
//   - latency: an accept at edge N gives out_valid_o high after edge N (1 cycle)
//   - SKID=1: entries main/skid
//     - in_ready_o = !skid_valid (registered)
//     - accept while main held (stall) -> writes skid
//     - transfer moves skid->main same edge
//     - full throughput (1/clk) when out_ready_i=1
//   - SKID=0: in_ready_o = !out_valid_o || out_ready_i (combinational)
//   - order preserved: FIFO, depth 1+SKID
//  Flush: at next edge all valids cleared; input in same cycle dropped; dec_cnt_o unaffected
//   except a transfer in the flush cycle still counts.
//  Counter: +1 per transfer, stops at 2^CNT_W-1 (no wrap); illegal entries count too.
//  Reset (async, rst_n=0): out_valid_o=0, all valids 0, in_ready_o=1, payload/ctrl_o/pc_o/imm_o=0,
//   dec_cnt_o=0; reset mid-stream drops buffered entries; no output transfer on release edge.
// TESTING
//  1 addi x1,x0,-5 (0xFFB00093), ready=1 -> next cycle ctrl_o alu_src,reg_write,op_imm,alu_op=10;
//    imm_o=0xFFFFFFFB; rd_o=1
//  2 sw/jalr/lui (0x00112223/0x000080E7/0x123450B7) -> mem_write only on sw; jalr reg_write=1,
//    mem_write=0; lui imm 0x12345000
//  3 out_ready_i=0 for 3 cycles, 3 back-to-back inputs (SKID=1) -> 2 accepted, in_ready_o=0,
//    outputs stable; release -> in order, no loss
//  4 flush_i with 2 entries buffered plus valid input -> out_valid_o=0 next cycle; dec_cnt_o
//    unchanged
//  5 instr 0x0000007F and 0x00000000 -> illegal=1, other ctrl 0, imm 0; dec_cnt_o +2
//  6 CNT_W=4, 20 transfers -> dec_cnt_o saturates at 15; rst_n low mid-stall -> all outputs 0 immediately

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// RV32I/RV64I decode stage: combinational opcode decode feeding an elastic ID/EX buffer
// with valid/ready handshake, flush, immediate generation and a saturating transfer counter.
module decode_ctrl_stage #(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [13:0]      ctrl_o,
    output logic [CNT_W-1:0] dec_cnt_o
);

    localparam int PW = 2 * XLEN + 39;

    logic signed [11:0] imm_i_s;
    logic signed [11:0] imm_s_s;
    logic signed [12:0] imm_b_s;
    logic signed [31:0] imm_u_s;
    logic signed [20:0] imm_j_s;

    assign imm_i_s = instr_i[31:20];
    assign imm_s_s = {instr_i[31:25], instr_i[11:7]};
    assign imm_b_s = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_s = {instr_i[31:12], 12'b0};
    assign imm_j_s = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // ctrl = {illegal,lui,auipc,jal,jalr,op_imm,alu_op[1:0],branch,mem_write,mem_read,reg_write,mem_to_reg,alu_src}
    logic [13:0]     ctrl_d;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        ctrl_d = '0;
        imm_d  = '0;
        case (instr_i[6:0])
            7'b0000011: begin ctrl_d = 14'h000F; imm_d = XLEN'(imm_i_s); end
            7'b0100011: begin ctrl_d = 14'h0011; imm_d = XLEN'(imm_s_s); end
            7'b0110011: begin ctrl_d = 14'h0084; end
            7'b0010011: begin ctrl_d = 14'h0185; imm_d = XLEN'(imm_i_s); end
            7'b1100011: begin ctrl_d = 14'h0060; imm_d = XLEN'(imm_b_s); end
            7'b1101111: begin ctrl_d = 14'h0404; imm_d = XLEN'(imm_j_s); end
            7'b1100111: begin ctrl_d = 14'h0205; imm_d = XLEN'(imm_i_s); end
            7'b0110111: begin ctrl_d = 14'h1004; imm_d = XLEN'(imm_u_s); end
            7'b0010111: begin ctrl_d = 14'h0804; imm_d = XLEN'(imm_u_s); end
            default:    begin ctrl_d = 14'h2000; end
        endcase
    end

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl;
    logic          main_valid;
    logic          accept;
    logic          xfer;

    assign in_pl = {pc_i, imm_d, instr_i[11:7], instr_i[19:15], instr_i[24:20],
                    instr_i[14:12], instr_i[31:25], ctrl_d};
    assign {pc_o, imm_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, ctrl_o} = main_pl;
    assign out_valid_o = main_valid;
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign xfer        = main_valid && out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic          skid_valid;
            logic [PW-1:0] skid_pl;
            logic          in_ready_q;

            assign in_ready_o = in_ready_q;

            // The head slot refills from skid first; skid only fills while the head is stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_pl    <= '0;
                    skid_valid <= 1'b0;
                    skid_pl    <= '0;
                    in_ready_q <= 1'b1;
                end else if (flush_i) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                end else if (xfer || !main_valid) begin
                    if (skid_valid) begin
                        main_pl    <= skid_pl;
                        main_valid <= 1'b1;
                    end else if (accept) begin
                        main_pl    <= in_pl;
                        main_valid <= 1'b1;
                    end else begin
                        main_valid <= 1'b0;
                    end
                    skid_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                end else if (accept) begin
                    skid_pl    <= in_pl;
                    skid_valid <= 1'b1;
                    in_ready_q <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready_o = !main_valid || out_ready_i;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_pl    <= '0;
                end else if (flush_i) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_pl    <= in_pl;
                    main_valid <= 1'b1;
                end else if (xfer) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_o <= '0;
        end else if (xfer && (dec_cnt_o != '1)) begin
            dec_cnt_o <= dec_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: skid build (CNT_W=4) plus a single-register build.
module tb_decode_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  f3_o;
    logic [6:0]  f7_o;
    logic [13:0] ctrl_o;
    logic [3:0]  cnt_o;

    logic        n_flush;
    logic        n_valid;
    logic        n_in_ready;
    logic [31:0] n_instr;
    logic [31:0] n_pc;
    logic        n_out_valid;
    logic        n_ready;
    logic [31:0] n_pc_o;
    logic [31:0] n_imm_o;
    logic [4:0]  n_rd_o, n_rs1_o, n_rs2_o;
    logic [2:0]  n_f3_o;
    logic [6:0]  n_f7_o;
    logic [13:0] n_ctrl_o;
    logic [3:0]  n_cnt_o;

    int n_tests;
    int n_fail;
    int cnt_exp;

    logic [31:0] v_instr [9];
    logic [13:0] v_ctrl  [9];
    logic [31:0] v_imm   [9];
    logic [4:0]  v_rd    [9];

    decode_ctrl_stage #(.XLEN(32), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .pc_o(pc_o), .imm_o(imm_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(f3_o), .funct7_o(f7_o), .ctrl_o(ctrl_o), .dec_cnt_o(cnt_o)
    );

    decode_ctrl_stage #(.XLEN(32), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(n_flush), .in_valid_i(n_valid), .in_ready_o(n_in_ready),
        .instr_i(n_instr), .pc_i(n_pc), .out_valid_o(n_out_valid), .out_ready_i(n_ready),
        .pc_o(n_pc_o), .imm_o(n_imm_o), .rd_o(n_rd_o), .rs1_o(n_rs1_o), .rs2_o(n_rs2_o),
        .funct3_o(n_f3_o), .funct7_o(n_f7_o), .ctrl_o(n_ctrl_o), .dec_cnt_o(n_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_cnt(input int n);
        cnt_exp = (cnt_exp + n > 15) ? 15 : cnt_exp + n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ctrl_o !== 14'h0 || imm_o !== 32'h0 ||
            pc_o !== 32'h0 || cnt_o !== 4'h0 || n_in_ready !== 1'b1 || n_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b ctrl=%h imm=%h pc=%h cnt=%0d nr=%b, expected 0 1 0 0 0 0 1",
                     out_valid, in_ready, ctrl_o, imm_o, pc_o, cnt_o, n_in_ready);
        end
        #3 rst_n = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || cnt_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b cnt=%0d, expected 0 0", out_valid, cnt_o);
        end
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            instr    = v_instr[i];
            pc       = 32'h1000 + 32'(i * 4);
            in_valid = 1'b1;
            step();
            n_tests++;
            if (out_valid !== 1'b1 || ctrl_o !== v_ctrl[i] || imm_o !== v_imm[i] ||
                rd_o !== v_rd[i] || pc_o !== pc) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b ctrl=%h imm=%h rd=%0d pc=%h, expected 1 %h %h %0d %h",
                         i, out_valid, ctrl_o, imm_o, rd_o, pc_o, v_ctrl[i], v_imm[i], v_rd[i], pc);
            end
            if (i == 1) begin
                n_tests++;
                if (rs1_o !== 5'd2 || rs2_o !== 5'd1 || f3_o !== 3'd2 || f7_o !== 7'd0) begin
                    n_fail++;
                    $display("FAIL sw_fields: got rs1=%0d rs2=%0d f3=%0d f7=%0d, expected 2 1 2 0",
                             rs1_o, rs2_o, f3_o, f7_o);
                end
            end
        end
        in_valid = 1'b0;
        step();
        add_cnt(9);
        n_tests++;
        if (out_valid !== 1'b0 || cnt_o !== 4'(cnt_exp)) begin
            n_fail++;
            $display("FAIL decode_drain: got v=%b cnt=%0d, expected 0 %0d", out_valid, cnt_o, cnt_exp);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'hFFB00093; pc = 32'h200;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || pc_o !== 32'h200) begin
            n_fail++;
            $display("FAIL stall_first: got r=%b v=%b pc=%h, expected 1 1 00000200", in_ready, out_valid, pc_o);
        end
        instr = 32'h123450B7; pc = 32'h204;
        step();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full: got in_ready=%b, expected 0", in_ready);
        end
        instr = 32'h002081B3; pc = 32'h208;
        step();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_o !== 32'h200 || ctrl_o !== 14'h0185) begin
            n_fail++;
            $display("FAIL stall_hold: got r=%b v=%b pc=%h ctrl=%h, expected 0 1 00000200 0185",
                     in_ready, out_valid, pc_o, ctrl_o);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || pc_o !== 32'h204 || ctrl_o !== 14'h1004 || imm_o !== 32'h12345000 ||
            in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_order: got v=%b pc=%h ctrl=%h imm=%h r=%b, expected 1 00000204 1004 12345000 1",
                     out_valid, pc_o, ctrl_o, imm_o, in_ready);
        end
        step();
        add_cnt(2);
        n_tests++;
        if (out_valid !== 1'b0 || cnt_o !== 4'(cnt_exp)) begin
            n_fail++;
            $display("FAIL stall_drain: got v=%b cnt=%0d, expected 0 %0d", out_valid, cnt_o, cnt_exp);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'hFFB00093; pc = 32'h300;
        step();
        instr = 32'h00112223; pc = 32'h304;
        step();
        instr = 32'h002081B3; pc = 32'h308;
        flush = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_o !== 4'(cnt_exp)) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b r=%b cnt=%0d, expected 0 1 %0d", out_valid, in_ready, cnt_o, cnt_exp);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b, expected 0", out_valid);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'hFFB00093; pc = 32'h310;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        add_cnt(1);
        n_tests++;
        if (out_valid !== 1'b0 || cnt_o !== 4'(cnt_exp)) begin
            n_fail++;
            $display("FAIL flush_xfer_count: got v=%b cnt=%0d, expected 0 %0d", out_valid, cnt_o, cnt_exp);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr = 32'h0000007F; pc = 32'h400;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || ctrl_o !== 14'h2000 || imm_o !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_7f: got v=%b ctrl=%h imm=%h, expected 1 2000 00000000", out_valid, ctrl_o, imm_o);
        end
        instr = 32'h00000000; pc = 32'h404;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || ctrl_o !== 14'h2000 || imm_o !== 32'h0 || pc_o !== 32'h404) begin
            n_fail++;
            $display("FAIL illegal_00: got v=%b ctrl=%h imm=%h pc=%h, expected 1 2000 00000000 00000404",
                     out_valid, ctrl_o, imm_o, pc_o);
        end
        in_valid = 1'b0;
        step();
        add_cnt(2);
        n_tests++;
        if (cnt_o !== 4'(cnt_exp)) begin
            n_fail++;
            $display("FAIL illegal_count: got cnt=%0d, expected %0d", cnt_o, cnt_exp);
        end
    endtask

    task automatic test_noskid();
        n_ready = 1'b0;
        n_valid = 1'b1;
        n_instr = 32'hFFB00093; n_pc = 32'h500;
        step();
        n_tests++;
        if (n_out_valid !== 1'b1 || n_in_ready !== 1'b0 || n_ctrl_o !== 14'h0185) begin
            n_fail++;
            $display("FAIL noskid_stall: got v=%b r=%b ctrl=%h, expected 1 0 0185", n_out_valid, n_in_ready, n_ctrl_o);
        end
        n_ready = 1'b1;
        #1;
        n_tests++;
        if (n_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_comb_ready: got in_ready=%b, expected 1", n_in_ready);
        end
        n_instr = 32'h123450B7; n_pc = 32'h504;
        step();
        n_tests++;
        if (n_out_valid !== 1'b1 || n_pc_o !== 32'h504 || n_ctrl_o !== 14'h1004 || n_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL noskid_throughput: got v=%b pc=%h ctrl=%h cnt=%0d, expected 1 00000504 1004 1",
                     n_out_valid, n_pc_o, n_ctrl_o, n_cnt_o);
        end
        n_valid = 1'b0;
        step();
        n_tests++;
        if (n_out_valid !== 1'b0 || n_cnt_o !== 4'd2) begin
            n_fail++;
            $display("FAIL noskid_drain: got v=%b cnt=%0d, expected 0 2", n_out_valid, n_cnt_o);
        end
    endtask

    task automatic test_saturate_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = v_instr[i % 9];
            pc    = 32'h600 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        step();
        add_cnt(20);
        n_tests++;
        if (cnt_o !== 4'd15 || cnt_exp != 15) begin
            n_fail++;
            $display("FAIL cnt_saturate: got cnt=%0d, expected 15", cnt_o);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'h123450B7; pc = 32'h700;
        step();
        instr = 32'h00112223; pc = 32'h704;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_o !== 32'h0 || imm_o !== 32'h0 ||
            ctrl_o !== 14'h0 || rd_o !== 5'h0 || cnt_o !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b r=%b pc=%h imm=%h ctrl=%h rd=%0d cnt=%0d, expected 0 1 0 0 0 0 0",
                     out_valid, in_ready, pc_o, imm_o, ctrl_o, rd_o, cnt_o);
        end
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || cnt_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_drop: got v=%b cnt=%0d, expected 0 0", out_valid, cnt_o);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cnt_exp = 0;
        v_instr = '{32'hFFB00093, 32'h00112223, 32'h000080E7, 32'h123450B7, 32'hFE000EE3,
                    32'h008000EF, 32'h00012083, 32'h002081B3, 32'h80000097};
        v_ctrl  = '{14'h0185, 14'h0011, 14'h0205, 14'h1004, 14'h0060,
                    14'h0404, 14'h000F, 14'h0084, 14'h0804};
        v_imm   = '{32'hFFFFFFFB, 32'h00000004, 32'h00000000, 32'h12345000, 32'hFFFFFFFC,
                    32'h00000008, 32'h00000000, 32'h00000000, 32'h80000000};
        v_rd    = '{5'd1, 5'd4, 5'd1, 5'd1, 5'd29, 5'd1, 5'd1, 5'd3, 5'd1};
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        n_flush = 1'b0; n_valid = 1'b0; n_ready = 1'b0; n_instr = '0; n_pc = '0;
        rst_n = 1'b0;
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_illegal();
        test_noskid();
        test_saturate_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
